// File: rtl/stepper_phase_driver.sv
// stepper_phase_driver
// Turns the 2-bit phase index of an up/down modulo-4 counter into a
// wave-drive pattern for a 4-coil stepper (bit0=A, bit1=B, bit2=A', bit3=B').
// Every accepted phase change is followed by a programmable all-coils-off
// dead time. The block also tracks step direction and a signed revolution
// count, and raises a sticky error on an illegal two-phase jump.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | driver disabled or just out of reset, coils off
// HOLD  | driving pat(cur_phase), watching the phase input for a change
// DEAD  | all coils off between two patterns, phase input ignored

module stepper_phase_driver #(
  parameter int DEAD_CYCLES = 2,
  parameter int POS_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       phase,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             dir,
  output logic [POS_W-1:0] turns,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DEAD = 2'd2
  } state_e;

  // Dead-time counter reload; a zero dead time never loads the counter.
  localparam logic [7:0]       DEAD_LOAD = (DEAD_CYCLES > 0) ? 8'(DEAD_CYCLES - 1) : 8'd0;
  localparam logic [POS_W-1:0] TURN_ONE  = POS_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       cur_phase_q, cur_phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       coil_q, coil_d;
  logic             busy_q, busy_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] turns_q, turns_d;
  logic             err_q, err_d;

  // Step classification of the live phase against the last accepted one.
  logic [1:0] delta;
  logic       phase_changed;
  logic       step_up;
  logic       step_dn;
  logic       step_jump;
  logic       wrap_up;
  logic       wrap_dn;

  function automatic logic [3:0] pat(input logic [1:0] p);
    logic [3:0] r;
    case (p)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0010;
      2'd2:    r = 4'b0100;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

  // Decode the modulo-4 distance between the input phase and cur_phase.
  always_comb begin
    delta         = phase - cur_phase_q;
    phase_changed = (delta != 2'd0);
    step_up       = (delta == 2'd1);
    step_dn       = (delta == 2'd3);
    step_jump     = (delta == 2'd2);
    // A full revolution is credited on 3->0 and debited on 0->3.
    wrap_up       = step_up && (cur_phase_q == 2'd3);
    wrap_dn       = step_dn && (cur_phase_q == 2'd0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cur_phase_d = cur_phase_q;
    cnt_d       = cnt_q;
    coil_d      = coil_q;
    busy_d      = busy_q;
    dir_d       = dir_q;
    turns_d     = turns_q;
    err_d       = err_q;

    if (!en) begin
      // Disable wins over any step sampled on this edge; nothing is tracked.
      state_d = IDLE;
      coil_d  = 4'b0000;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Resync: adopt the current phase without counting a step.
          cur_phase_d = phase;
          coil_d      = pat(phase);
          busy_d      = 1'b0;
          state_d     = HOLD;
        end

        HOLD: begin
          coil_d = pat(cur_phase_q);
          busy_d = 1'b0;
          if (phase_changed) begin
            if (step_up) begin
              dir_d = 1'b1;
              if (wrap_up) turns_d = turns_q + TURN_ONE;
            end else if (step_dn) begin
              dir_d = 1'b0;
              if (wrap_dn) turns_d = turns_q - TURN_ONE;
            end else if (step_jump) begin
              err_d = 1'b1;
            end
            cur_phase_d = phase;
            if (DEAD_CYCLES > 0) begin
              coil_d  = 4'b0000;
              busy_d  = 1'b1;
              cnt_d   = DEAD_LOAD;
              state_d = DEAD;
            end else begin
              coil_d  = pat(phase);
            end
          end
        end

        DEAD: begin
          // Any phase movement here is picked up on the first HOLD cycle.
          if (cnt_q == 8'd0) begin
            coil_d  = pat(cur_phase_q);
            busy_d  = 1'b0;
            state_d = HOLD;
          end else begin
            coil_d  = 4'b0000;
            busy_d  = 1'b1;
            cnt_d   = cnt_q - 8'd1;
          end
        end

        default: begin
          state_d = IDLE;
          coil_d  = 4'b0000;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Clear acts regardless of state or enable and beats a same-edge update.
    if (clr) begin
      turns_d = '0;
      err_d   = 1'b0;
    end
  end

  // State and output registers; reset forces the coils off immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_phase_q <= 2'd0;
      cnt_q       <= 8'd0;
      coil_q      <= 4'b0000;
      busy_q      <= 1'b0;
      dir_q       <= 1'b0;
      turns_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_phase_q <= cur_phase_d;
      cnt_q       <= cnt_d;
      coil_q      <= coil_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
      turns_q     <= turns_d;
      err_q       <= err_d;
    end
  end

  assign coil  = coil_q;
  assign busy  = busy_q;
  assign dir   = dir_q;
  assign turns = turns_q;
  assign err   = err_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Bench for stepper_phase_driver: two instances (dead time 2 / 8-bit turns,
// and zero dead time / 2-bit turns). Stimulus pushes hand-computed expected
// outputs tagged with the cycle they must appear in; a monitor pops and
// compares them on the falling edge.
module tb_stepper_phase_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, clr_a = 1'b0;
  logic [1:0] phase_a = 2'd0;
  logic       en_b = 1'b0, clr_b = 1'b0;
  logic [1:0] phase_b = 2'd0;

  logic [3:0] coil_a, coil_b;
  logic       busy_a, busy_b, dir_a, dir_b, err_a, err_b;
  logic [7:0] turns_a;
  logic [1:0] turns_b;

  stepper_phase_driver #(.DEAD_CYCLES(2), .POS_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .phase(phase_a),
    .coil(coil_a), .busy(busy_a), .dir(dir_a), .turns(turns_a), .err(err_a)
  );

  stepper_phase_driver #(.DEAD_CYCLES(0), .POS_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .phase(phase_b),
    .coil(coil_b), .busy(busy_b), .dir(dir_b), .turns(turns_b), .err(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         sel;
    string      name;
    logic [3:0] coil;
    logic       busy;
    logic       dir;
    int         turns;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect the given outputs k edges from now (k=0: before the next edge).
  task automatic push(input bit s, input int k, input string nm, input logic [3:0] c,
                      input logic b, input logic d, input int t, input logic e);
    exp_t x;
    x.cyc = cyc + k; x.sel = s; x.name = nm;
    x.coil = c; x.busy = b; x.dir = d; x.turns = t; x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: compare every entry due in this cycle.
  initial forever begin
    exp_t       x;
    logic [3:0] c;
    logic       b, d, e;
    int         t;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      if (x.sel) begin
        c = coil_b; b = busy_b; d = dir_b; e = err_b; t = int'($signed(turns_b));
      end else begin
        c = coil_a; b = busy_a; d = dir_a; e = err_a; t = int'($signed(turns_a));
      end
      n_chk++;
      if (x.cyc != cyc)
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", x.name, x.cyc, cyc);
      else if (c === x.coil && b === x.busy && d === x.dir && t == x.turns && e === x.err)
        n_pass++;
      else
        $display("FAIL %s: got coil=%b busy=%b dir=%b turns=%0d err=%b, expected coil=%b busy=%b dir=%b turns=%0d err=%b",
                 x.name, c, b, d, t, e, x.coil, x.busy, x.dir, x.turns, x.err);
    end
  end

  // One accepted step on dut_a: two dead cycles, then the new pattern.
  task automatic step_a(input logic [1:0] ph, input string nm, input logic [3:0] c,
                        input logic d, input int t, input logic e);
    phase_a = ph;
    push(0, 1, {nm, "_dead1"}, 4'b0000, 1'b1, d, t, e);
    push(0, 2, {nm, "_dead2"}, 4'b0000, 1'b1, d, t, e);
    push(0, 3, nm, c, 1'b0, d, t, e);
    tick(3);
  endtask

  initial begin
    logic [3:0] pats [4];
    logic [1:0] seq  [4];
    int         cur_t;
    pats = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq  = '{2'd1, 2'd2, 2'd3, 2'd0};

    tick(2);
    rst = 1'b0;
    push(0, 1, "reset", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    push(1, 1, "reset_b", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    tick(1);

    // Enable with phase 2, then resync to phase 0 through IDLE.
    phase_a = 2'd2; en_a = 1'b1;
    push(0, 1, "en_hold", 4'b0100, 1'b0, 1'b0, 0, 1'b0);
    tick(1);
    en_a = 1'b0;
    push(0, 1, "en_off", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    tick(1);
    phase_a = 2'd0; en_a = 1'b1;
    push(0, 1, "resync0", 4'b0001, 1'b0, 1'b0, 0, 1'b0);
    tick(1);

    // Up steps through one revolution, then down through one and one more.
    step_a(2'd1, "up1",    4'b0010, 1'b1, 0, 1'b0);
    step_a(2'd2, "up2",    4'b0100, 1'b1, 0, 1'b0);
    step_a(2'd3, "up3",    4'b1000, 1'b1, 0, 1'b0);
    step_a(2'd0, "rev_up", 4'b0001, 1'b1, 1, 1'b0);
    step_a(2'd3, "dn3",    4'b1000, 1'b0, 0, 1'b0);
    step_a(2'd2, "dn2",    4'b0100, 1'b0, 0, 1'b0);
    step_a(2'd1, "dn1",    4'b0010, 1'b0, 0, 1'b0);
    step_a(2'd0, "dn0",    4'b0001, 1'b0, 0, 1'b0);
    step_a(2'd3, "rev_dn", 4'b1000, 1'b0, -1, 1'b0);

    // Illegal 1->3 jump, then clr on the same edge as a 3->0 step.
    step_a(2'd0, "up0",    4'b0001, 1'b1, 0, 1'b0);
    step_a(2'd1, "up1b",   4'b0010, 1'b1, 0, 1'b0);
    step_a(2'd3, "jump",   4'b1000, 1'b1, 0, 1'b1);
    phase_a = 2'd0; clr_a = 1'b1;
    push(0, 1, "clr_dead", 4'b0000, 1'b1, 1'b1, 0, 1'b0);
    push(0, 3, "clr_pat",  4'b0001, 1'b0, 1'b1, 0, 1'b0);
    tick(1);
    clr_a = 1'b0;
    tick(2);

    // Disable during dead time; a phase jump while disabled is discarded.
    phase_a = 2'd1;
    push(0, 1, "dis_dead", 4'b0000, 1'b1, 1'b1, 0, 1'b0);
    tick(1);
    en_a = 1'b0;
    push(0, 1, "dis_idle", 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    tick(1);
    phase_a = 2'd3;
    push(0, 1, "dis_ignore", 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    tick(1);
    en_a = 1'b1;
    push(0, 1, "reen", 4'b1000, 1'b0, 1'b1, 0, 1'b0);
    tick(1);
    push(0, 1, "hold_stable", 4'b1000, 1'b0, 1'b1, 0, 1'b0);
    tick(2);

    // Reset raised between edges while in HOLD.
    rst = 1'b1;
    push(0, 0, "async_rst", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    en_a = 1'b0;
    tick(2);
    rst = 1'b0;
    push(0, 1, "post_rst_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    tick(1);
    phase_a = 2'd3; en_a = 1'b1;
    push(0, 1, "rst_resync", 4'b1000, 1'b0, 1'b0, 0, 1'b0);
    tick(1);

    // 3->0 accepted, then 0->1->2 entirely inside the dead time.
    phase_a = 2'd0;
    push(0, 1, "dd_dead", 4'b0000, 1'b1, 1'b1, 1, 1'b0);
    push(0, 3, "dd_hold", 4'b0001, 1'b0, 1'b1, 1, 1'b0);
    push(0, 4, "dd_err",  4'b0000, 1'b1, 1'b1, 1, 1'b1);
    push(0, 6, "dd_pat",  4'b0100, 1'b0, 1'b1, 1, 1'b1);
    tick(1);
    phase_a = 2'd1;
    tick(1);
    phase_a = 2'd2;
    tick(4);
    en_a = 1'b0;

    // Zero dead time: pattern follows with one cycle latency, 2-bit turns wrap.
    phase_b = 2'd0; en_b = 1'b1;
    push(1, 1, "b_en", 4'b0001, 1'b0, 1'b0, 0, 1'b0);
    tick(1);
    cur_t = 0;
    for (int r = 1; r <= 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        phase_b = seq[i];
        if (seq[i] == 2'd0) begin
          cur_t = r % 4;
          if (cur_t >= 2) cur_t -= 4;
        end
        push(1, 1, $sformatf("b_rev%0d_p%0d", r, seq[i]), pats[seq[i]], 1'b0, 1'b1, cur_t, 1'b0);
        tick(1);
      end
    end
    phase_b = 2'd3;
    push(1, 1, "b_wrap_dn", 4'b1000, 1'b0, 1'b0, -1, 1'b0);
    tick(1);
    en_b = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
